// File: rtl/axis_deadlock_detector_if.sv
// rtl/axis_deadlock_detector_if.sv - monitor-side signal bundle for the deadlock detector
interface axis_deadlock_detector_if #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_INST = 1
);
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_INST-1:0] inst_idle_sigs;
  logic [NUM_INST-1:0] inst_block_sigs;
  logic                clear;
  logic                block;
  logic [NUM_AXIS-1:0] block_axis_mask;
  logic [NUM_INST-1:0] block_inst_mask;
  logic [7:0]          deadlock_count;

  // Kernel monitor top: drives the stall vectors and clear, observes the verdict.
  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    input  block, block_axis_mask, block_inst_mask, deadlock_count
  );

  // Detector side.
  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
    output block, block_axis_mask, block_inst_mask, deadlock_count
  );
endinterface

// File: rtl/axis_deadlock_detector.sv
// rtl/axis_deadlock_detector.sv - declares deadlock when one non-idle stall pattern persists
module axis_deadlock_detector #(
  parameter int NUM_AXIS  = 2,
  parameter int NUM_INST  = 1,
  parameter int THRESHOLD = 1024,
  parameter int CNT_W     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  axis_deadlock_detector_if.slave  mon
);
  localparam int PAT_W = NUM_AXIS + NUM_INST;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WATCH   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [PAT_W-1:0]   snap, snap_nxt, pattern;
  logic               stall;
  logic               declare;
  logic               block_q;
  logic [NUM_AXIS-1:0] axis_mask_q;
  logic [NUM_INST-1:0] inst_mask_q;
  logic [7:0]         dl_count_q;

  // A stall only matters while at least one instance is still doing work.
  assign stall   = (|mon.axis_block_sigs | |mon.inst_block_sigs) & ~(&mon.inst_idle_sigs);
  assign pattern = {mon.axis_block_sigs, mon.inst_block_sigs};
  assign cnt_inc = cnt + CNT_W'(1);

  // Next-state logic; clear overrides everything, including a threshold edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    declare   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!mon.clear && stall) begin
          snap_nxt = pattern;
          cnt_nxt  = CNT_W'(1);
          if (THRESHOLD == 1) begin
            state_nxt = BLOCKED;
            declare   = 1'b1;
          end else begin
            state_nxt = WATCH;
          end
        end
      end
      WATCH: begin
        if (mon.clear || !stall) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (pattern == snap) begin
          // cnt is always below THRESHOLD here, so cnt_inc cannot overshoot.
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_W'(THRESHOLD)) begin
            state_nxt = BLOCKED;
            declare   = 1'b1;
          end
        end else begin
          // A changed pattern means something moved: restart persistence.
          snap_nxt = pattern;
          cnt_nxt  = CNT_W'(1);
        end
      end
      BLOCKED: begin
        if (mon.clear) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and pattern snapshot registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      snap  <= snap_nxt;
    end
  end

  // Registered outputs: sticky flag, masks captured at declaration, saturating count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      block_q     <= 1'b0;
      axis_mask_q <= '0;
      inst_mask_q <= '0;
      dl_count_q  <= '0;
    end else begin
      block_q <= (state_nxt == BLOCKED);
      if (declare) begin
        axis_mask_q <= mon.axis_block_sigs;
        inst_mask_q <= mon.inst_block_sigs;
        if (dl_count_q != 8'hFF) begin
          dl_count_q <= dl_count_q + 8'd1;
        end
      end
    end
  end

  assign mon.block           = block_q;
  assign mon.block_axis_mask = axis_mask_q;
  assign mon.block_inst_mask = inst_mask_q;
  assign mon.deadlock_count  = dl_count_q;
endmodule

// File: tb/tb_axis_deadlock_detector.sv
// tb/tb_axis_deadlock_detector.sv - scoreboard bench for axis_deadlock_detector
module tb_axis_deadlock_detector;
  localparam int TH = 4;

  typedef struct packed {
    logic       blk;
    logic [1:0] am;
    logic       im;
    logic [7:0] dc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  // Reference model: run length of the current identical stall pattern.
  logic       m_blocked;
  int         m_run;
  logic [2:0] m_pat;
  logic [1:0] m_am;
  logic       m_im;
  logic [7:0] m_dc;

  axis_deadlock_detector_if #(.NUM_AXIS(2), .NUM_INST(1)) mon ();

  axis_deadlock_detector #(
    .NUM_AXIS(2), .NUM_INST(1), .THRESHOLD(TH), .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mon  (mon.slave)
  );

  always #5 clock = ~clock;

  // Scoreboard consumer: compare each edge's outputs one time unit after the edge.
  always @(posedge clock) begin
    exp_t e;
    exp_t g;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g = {mon.block, mon.block_axis_mask, mon.block_inst_mask, mon.deadlock_count};
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL scoreboard t=%0t got blk=%b am=%b im=%b dc=%0d want blk=%b am=%b im=%b dc=%0d",
                 $time, g.blk, g.am, g.im, g.dc, e.blk, e.am, e.im, e.dc);
      end
    end
  end

  task automatic model_reset();
    m_blocked = 1'b0; m_run = 0; m_pat = '0; m_am = '0; m_im = 1'b0; m_dc = '0;
  endtask

  // Drive one cycle of stimulus, push the expected post-edge outputs, return at edge+2.
  task automatic step(input logic [1:0] a, input logic idl, input logic ib, input logic clr);
    logic       st;
    logic [2:0] pat;
    mon.axis_block_sigs = a;
    mon.inst_idle_sigs  = idl;
    mon.inst_block_sigs = ib;
    mon.clear           = clr;
    st  = (|a | ib) & ~idl;
    pat = {a, ib};
    if (clr) begin
      m_blocked = 1'b0;
      m_run     = 0;
    end else if (!m_blocked) begin
      if (!st) m_run = 0;
      else if (m_run > 0 && pat == m_pat) m_run++;
      else begin m_pat = pat; m_run = 1; end
      if (m_run == TH) begin
        m_blocked = 1'b1;
        m_am = a;
        m_im = ib;
        if (m_dc != 8'hFF) m_dc = m_dc + 8'd1;
      end
    end
    sb.push_back('{blk: m_blocked, am: m_am, im: m_im, dc: m_dc});
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    mon.axis_block_sigs = 2'b00;
    mon.inst_idle_sigs  = 1'b0;
    mon.inst_block_sigs = 1'b0;
    mon.clear           = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({mon.block, mon.block_axis_mask, mon.block_inst_mask, mon.deadlock_count} !== 12'd0) begin
      failures++;
      $display("FAIL reset_state got blk=%b dc=%0d want all zero", mon.block, mon.deadlock_count);
    end
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < TH; i++) step(2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mon.block !== 1'b1 || mon.block_axis_mask !== 2'b01 || mon.deadlock_count !== 8'd1) begin
      failures++;
      $display("FAIL basic_declare got blk=%b am=%b dc=%0d want 1 01 1",
               mon.block, mon.block_axis_mask, mon.deadlock_count);
    end
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mon.deadlock_count !== 8'd1) begin
      failures++;
      $display("FAIL basic_hold got dc=%0d want 1", mon.deadlock_count);
    end
    step(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_pattern_change();
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 1'b0, 1'b0, 1'b0);
      checks++;
      if (mon.block !== 1'b0) begin
        failures++;
        $display("FAIL change_early got blk=%b want 0", mon.block);
      end
    end
    step(2'b10, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mon.block !== 1'b1 || mon.block_axis_mask !== 2'b10 || mon.deadlock_count !== 8'd2) begin
      failures++;
      $display("FAIL change_declare got blk=%b am=%b dc=%0d want 1 10 2",
               mon.block, mon.block_axis_mask, mon.deadlock_count);
    end
    step(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_gap();
    logic [1:0] seq [7];
    seq = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11};
    for (int i = 0; i < 7; i++) begin
      step(seq[i], 1'b0, 1'b0, 1'b0);
      checks++;
      if (mon.block !== 1'b0) begin
        failures++;
        $display("FAIL gap_step%0d got blk=%b want 0", i, mon.block);
      end
    end
    step(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_masked();
    for (int i = 0; i < 10; i++) step(2'b01, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mon.block !== 1'b0 || mon.deadlock_count !== 8'd2) begin
      failures++;
      $display("FAIL idle_masked got blk=%b dc=%0d want 0 2", mon.block, mon.deadlock_count);
    end
  endtask

  task automatic test_clear_restart();
    for (int i = 0; i < TH; i++) step(2'b01, 1'b0, 1'b1, 1'b0);
    checks++;
    if (mon.block !== 1'b1 || mon.block_inst_mask !== 1'b1 || mon.deadlock_count !== 8'd3) begin
      failures++;
      $display("FAIL clear_first got blk=%b im=%b dc=%0d want 1 1 3",
               mon.block, mon.block_inst_mask, mon.deadlock_count);
    end
    step(2'b01, 1'b0, 1'b1, 1'b1);
    checks++;
    if (mon.block !== 1'b0 || mon.block_axis_mask !== 2'b01) begin
      failures++;
      $display("FAIL clear_release got blk=%b am=%b want 0 01", mon.block, mon.block_axis_mask);
    end
    for (int i = 0; i < TH; i++) step(2'b01, 1'b0, 1'b1, 1'b0);
    checks++;
    if (mon.block !== 1'b1 || mon.deadlock_count !== 8'd4) begin
      failures++;
      $display("FAIL clear_reassert got blk=%b dc=%0d want 1 4", mon.block, mon.deadlock_count);
    end
    step(2'b00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_clear_on_threshold();
    for (int i = 0; i < TH - 1; i++) step(2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b1);
    checks++;
    if (mon.block !== 1'b0 || mon.deadlock_count !== 8'd4) begin
      failures++;
      $display("FAIL clear_wins got blk=%b dc=%0d want 0 4", mon.block, mon.deadlock_count);
    end
    step(2'b01, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    step(2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b01, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (mon.block !== 1'b0 || mon.deadlock_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_watch got blk=%b dc=%0d want 0 0", mon.block, mon.deadlock_count);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < TH - 1; i++) step(2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mon.block !== 1'b0) begin
      failures++;
      $display("FAIL reset_fresh_early got blk=%b want 0", mon.block);
    end
    step(2'b01, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mon.block !== 1'b1 || mon.deadlock_count !== 8'd1) begin
      failures++;
      $display("FAIL reset_fresh_declare got blk=%b dc=%0d want 1 1", mon.block, mon.deadlock_count);
    end
    #1 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({mon.block, mon.block_axis_mask, mon.block_inst_mask, mon.deadlock_count} !== 12'd0) begin
      failures++;
      $display("FAIL reset_blocked got blk=%b am=%b im=%b dc=%0d want all zero",
               mon.block, mon.block_axis_mask, mon.block_inst_mask, mon.deadlock_count);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    step(2'b01, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern_change();
    test_gap();
    test_idle_masked();
    test_clear_restart();
    test_clear_on_threshold();
    test_async_reset();
    @(posedge clock);
    #3;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
